// File: rtl/sympl_alu_pkg.sv
// sympl_alu_pkg: condition-code encodings and flag bit positions shared by the ALU stages
package sympl_alu_pkg;
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;
    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: evaluates a 4-bit ARM-order condition code against {N,Z,C,V}
module cond_eval
    import sympl_alu_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond,
    output logic       cond_true
);
    logic n, z, c, v;
    assign n = flags[FLG_N];
    assign z = flags[FLG_Z];
    assign c = flags[FLG_C];
    assign v = flags[FLG_V];
    // decode the condition against the supplied flags
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_EQ: cond_true = z;
            COND_NE: cond_true = ~z;
            COND_CS: cond_true = c;
            COND_CC: cond_true = ~c;
            COND_MI: cond_true = n;
            COND_PL: cond_true = ~n;
            COND_VS: cond_true = v;
            COND_VC: cond_true = ~v;
            COND_HI: cond_true = c & ~z;
            COND_LS: cond_true = ~c | z;
            COND_GE: cond_true = n == v;
            COND_LT: cond_true = n != v;
            COND_GT: cond_true = ~z & (n == v);
            COND_LE: cond_true = z | (n != v);
            COND_AL: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end
endmodule

// File: rtl/sub_flags_stage.sv
// sub_flags_stage: two-deep registered flag/condition/writeback stage behind the subtractor
module sub_flags_stage
    import sympl_alu_pkg::*;
#(
    parameter int DW   = 64,
    parameter int TAGW = 6
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [DW-1:0]   DIFF,
    input  logic            COUT,
    input  logic            OVO,
    input  logic            SET_FLAGS,
    input  logic            WB_EN,
    input  logic [3:0]      COND,
    input  logic [TAGW-1:0] TAG_IN,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [DW-1:0]   RESULT,
    output logic [TAGW-1:0] TAG_OUT,
    output logic            WB_OUT,
    output logic            COND_TRUE,
    output logic [3:0]      FLAGS,
    output logic            STICKY_V,
    input  logic            CLR_STICKY
);
    logic            v1, v2, adv2, accept, ct1;
    logic [DW-1:0]   diff1;
    logic [TAGW-1:0] tag1;
    logic            wb1, sf1;
    logic [3:0]      cond1, nzcv1, nzcv_in;

    assign nzcv_in[FLG_N] = DIFF[DW-1];
    assign nzcv_in[FLG_Z] = DIFF == '0;
    assign nzcv_in[FLG_C] = COUT;
    assign nzcv_in[FLG_V] = OVO;

    assign adv2      = v1 & (~v2 | OUT_READY);
    assign IN_READY  = ~v1 | adv2;
    assign accept    = IN_VALID & IN_READY;
    assign OUT_VALID = v2;

    cond_eval u_cond (.flags(nzcv1), .cond(cond1), .cond_true(ct1));

    // stage 1: capture the incoming op and its derived flags
    always_ff @(posedge CLK) begin
        if (RESET) begin
            v1    <= 1'b0;
            diff1 <= '0;
            tag1  <= '0;
            wb1   <= 1'b0;
            sf1   <= 1'b0;
            cond1 <= '0;
            nzcv1 <= '0;
        end else begin
            v1 <= accept | (v1 & ~adv2);
            if (accept) begin
                diff1 <= DIFF;
                tag1  <= TAG_IN;
                wb1   <= WB_EN;
                sf1   <= SET_FLAGS;
                cond1 <= COND;
                nzcv1 <= nzcv_in;
            end
        end
    end

    // stage 2 and architectural flags: updated in program order as ops leave stage 1
    always_ff @(posedge CLK) begin
        if (RESET) begin
            v2        <= 1'b0;
            RESULT    <= '0;
            TAG_OUT   <= '0;
            WB_OUT    <= 1'b0;
            COND_TRUE <= 1'b0;
            FLAGS     <= '0;
            STICKY_V  <= 1'b0;
        end else begin
            v2 <= adv2 | (v2 & ~OUT_READY);
            if (adv2) begin
                RESULT    <= diff1;
                TAG_OUT   <= tag1;
                WB_OUT    <= wb1;
                COND_TRUE <= ct1;
                if (sf1)
                    FLAGS <= nzcv1;
            end
            if (adv2 & sf1 & nzcv1[FLG_V])
                STICKY_V <= 1'b1;
            else if (CLR_STICKY)
                STICKY_V <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sub_flags_stage.sv
// tb_sub_flags_stage: directed vector table plus stall, sticky and reset sequences
module tb_sub_flags_stage;
    import sympl_alu_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET, IN_VALID, IN_READY, COUT, OVO, SET_FLAGS, WB_EN;
    logic [63:0] DIFF, RESULT;
    logic [3:0]  COND, FLAGS;
    logic [5:0]  TAG_IN, TAG_OUT;
    logic        OUT_VALID, OUT_READY, WB_OUT, COND_TRUE, STICKY_V, CLR_STICKY;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [63:0] diff;
        logic        cout, ovo, sf, wb;
        logic [3:0]  cond;
        logic        ct;
        logic [3:0]  flags;
        logic        sticky;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    sub_flags_stage #(.DW(64), .TAGW(6)) dut (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .DIFF(DIFF), .COUT(COUT), .OVO(OVO), .SET_FLAGS(SET_FLAGS), .WB_EN(WB_EN),
        .COND(COND), .TAG_IN(TAG_IN), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .RESULT(RESULT), .TAG_OUT(TAG_OUT), .WB_OUT(WB_OUT), .COND_TRUE(COND_TRUE),
        .FLAGS(FLAGS), .STICKY_V(STICKY_V), .CLR_STICKY(CLR_STICKY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [63:0] d, input logic c, input logic o, input logic sf,
                         input logic wb, input logic [3:0] cd, input logic [5:0] tg);
        IN_VALID = 1'b1; DIFF = d; COUT = c; OVO = o; SET_FLAGS = sf; WB_EN = wb; COND = cd; TAG_IN = tg;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        vecs[0]  = '{64'h0, 1'b1, 1'b0, 1'b1, 1'b1, COND_EQ, 1'b1, 4'b0110, 1'b0};
        vecs[1]  = '{64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b1, COND_CC, 1'b1, 4'b1000, 1'b0};
        vecs[2]  = '{64'h0, 1'b1, 1'b0, 1'b0, 1'b0, COND_EQ, 1'b1, 4'b1000, 1'b0};
        vecs[3]  = '{64'h4, 1'b1, 1'b0, 1'b1, 1'b1, COND_HI, 1'b1, 4'b0010, 1'b0};
        vecs[4]  = '{64'h4, 1'b1, 1'b0, 1'b0, 1'b1, COND_LS, 1'b0, 4'b0010, 1'b0};
        vecs[5]  = '{64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0, COND_MI, 1'b1, 4'b0010, 1'b0};
        vecs[6]  = '{64'h4, 1'b1, 1'b0, 1'b0, 1'b1, COND_PL, 1'b1, 4'b0010, 1'b0};
        vecs[7]  = '{64'h0, 1'b1, 1'b0, 1'b0, 1'b0, COND_NE, 1'b0, 4'b0010, 1'b0};
        vecs[8]  = '{64'h4, 1'b0, 1'b0, 1'b0, 1'b1, COND_CS, 1'b0, 4'b0010, 1'b0};
        vecs[9]  = '{64'h4, 1'b1, 1'b0, 1'b0, 1'b1, COND_GT, 1'b1, 4'b0010, 1'b0};
        vecs[10] = '{64'h0, 1'b1, 1'b0, 1'b0, 1'b0, COND_LE, 1'b1, 4'b0010, 1'b0};
        vecs[11] = '{64'h4, 1'b1, 1'b0, 1'b0, 1'b1, COND_NV, 1'b0, 4'b0010, 1'b0};
        vecs[12] = '{64'h4, 1'b1, 1'b0, 1'b0, 1'b1, COND_AL, 1'b1, 4'b0010, 1'b0};
        vecs[13] = '{64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, COND_GE, 1'b0, 4'b0010, 1'b0};
        vecs[14] = '{64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1, COND_LT, 1'b1, 4'b0011, 1'b1};
        vecs[15] = '{64'h1, 1'b1, 1'b1, 1'b0, 1'b1, COND_VS, 1'b1, 4'b0011, 1'b1};
        vecs[16] = '{64'h1, 1'b1, 1'b0, 1'b0, 1'b0, COND_VC, 1'b1, 4'b0011, 1'b1};

        RESET = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1; CLR_STICKY = 1'b0;
        DIFF = '0; COUT = 1'b0; OVO = 1'b0; SET_FLAGS = 1'b0; WB_EN = 1'b0; COND = '0; TAG_IN = '0;
        repeat (3) step();
        RESET = 1'b0;
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_in_ready", IN_READY, 1);
        chk("rst_result", RESULT, 0);
        chk("rst_tag", TAG_OUT, 0);
        chk("rst_wb", WB_OUT, 0);
        chk("rst_cond_true", COND_TRUE, 0);
        chk("rst_flags", FLAGS, 0);
        chk("rst_sticky", STICKY_V, 0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].diff, vecs[i].cout, vecs[i].ovo, vecs[i].sf, vecs[i].wb, vecs[i].cond, 6'(i + 1));
            chk($sformatf("v%0d_in_ready", i), IN_READY, 1);
            step();
            IN_VALID = 1'b0;
            chk($sformatf("v%0d_latency", i), OUT_VALID, 0);
            step();
            chk($sformatf("v%0d_out_valid", i), OUT_VALID, 1);
            chk($sformatf("v%0d_result", i), RESULT, vecs[i].diff);
            chk($sformatf("v%0d_tag", i), TAG_OUT, 64'(i + 1));
            chk($sformatf("v%0d_wb", i), WB_OUT, vecs[i].wb);
            chk($sformatf("v%0d_cond_true", i), COND_TRUE, vecs[i].ct);
            chk($sformatf("v%0d_flags", i), FLAGS, vecs[i].flags);
            chk($sformatf("v%0d_sticky", i), STICKY_V, vecs[i].sticky);
        end

        // sticky set and clear on the same edge: set wins; clear alone next edge
        drive(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1, COND_LT, 6'h20);
        step();
        IN_VALID = 1'b0;
        CLR_STICKY = 1'b1;
        step();
        chk("sticky_set_wins", STICKY_V, 1);
        chk("sticky_flags", FLAGS, 4'b0011);
        step();
        CLR_STICKY = 1'b0;
        chk("sticky_cleared", STICKY_V, 0);

        // backpressure: A, B accepted, C held until OUT_READY rises
        OUT_READY = 1'b0;
        drive(64'hA, 1'b1, 1'b0, 1'b0, 1'b1, COND_AL, 6'h0A);
        step();
        chk("bp_ready_after_a", IN_READY, 1);
        drive(64'hB, 1'b1, 1'b0, 1'b0, 1'b1, COND_AL, 6'h0B);
        step();
        drive(64'hC, 1'b1, 1'b0, 1'b0, 1'b1, COND_AL, 6'h0C);
        chk("bp_full_ready", IN_READY, 0);
        chk("bp_a_valid", OUT_VALID, 1);
        chk("bp_a_tag", TAG_OUT, 6'h0A);
        step();
        chk("bp_hold_ready", IN_READY, 0);
        chk("bp_hold_tag", TAG_OUT, 6'h0A);
        chk("bp_hold_result", RESULT, 64'hA);
        OUT_READY = 1'b1;
        #1;
        chk("bp_ready_comb", IN_READY, 1);
        step();
        IN_VALID = 1'b0;
        chk("bp_b_valid", OUT_VALID, 1);
        chk("bp_b_tag", TAG_OUT, 6'h0B);
        chk("bp_b_result", RESULT, 64'hB);
        step();
        chk("bp_c_valid", OUT_VALID, 1);
        chk("bp_c_tag", TAG_OUT, 6'h0C);
        chk("bp_c_result", RESULT, 64'hC);
        step();
        chk("bp_drained", OUT_VALID, 0);
        chk("bp_flags_kept", FLAGS, 4'b0011);

        // reset with both stages occupied discards them without a flag update
        OUT_READY = 1'b0;
        drive(64'hD, 1'b1, 1'b0, 1'b0, 1'b1, COND_AL, 6'h0D);
        step();
        drive(64'h0, 1'b1, 1'b1, 1'b1, 1'b1, COND_EQ, 6'h0E);
        step();
        IN_VALID = 1'b0;
        chk("rm_full", IN_READY, 0);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        OUT_READY = 1'b1;
        chk("rm_out_valid", OUT_VALID, 0);
        chk("rm_flags", FLAGS, 0);
        chk("rm_sticky", STICKY_V, 0);
        chk("rm_in_ready", IN_READY, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("rm_no_output_%0d", k), OUT_VALID, 0);
        end
        chk("rm_flags_after", FLAGS, 0);
        chk("rm_sticky_after", STICKY_V, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
